// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared definitions for the 24Cxx EEPROM transaction sequencer.
//   - engine command codes driven on bus_cmd
//   - FSM state enum
//   - default 7-bit device address
//   - small state classification helpers
package eeprom_pkg;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_STOP  = 2'd3;

  localparam logic [6:0] DEF_DEV_ADDR = 7'b1010_000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_DEVW,
    S_WADDR,
    S_WDATA,
    S_RSTART,
    S_DEVR,
    S_RDATA,
    S_STOP,
    S_WAIT_WR,
    S_DONE
  } state_t;

  // States that issue exactly one engine command and then wait for bus_done.
  function automatic logic is_step(input state_t s);
    return (s inside {S_START, S_DEVW, S_WADDR, S_WDATA,
                      S_RSTART, S_DEVR, S_RDATA, S_STOP});
  endfunction

  // Step states whose command is a WRITE, i.e. where the slave ACK matters.
  function automatic logic is_write_step(input state_t s);
    return (s inside {S_DEVW, S_WADDR, S_WDATA, S_DEVR});
  endfunction

endpackage

// File: rtl/eeprom_wait_timer.sv
// eeprom_wait_timer: down-counter that times the EEPROM internal write cycle.
// Ports:
//   sclk, srst_n  clock / async active-low reset
//   start         load the counter with 'load' and begin counting
//   load          initial count (wait length minus one)
//   expired       high in the final cycle of the wait (count reached 0)
module eeprom_wait_timer #(
  parameter int CNT_W = 8
) (
  input  logic             sclk,
  input  logic             srst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] load,
  output logic             expired
);

  logic [CNT_W-1:0] count;
  logic             active;

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      count  <= '0;
      active <= 1'b0;
    end else if (start) begin
      count  <= load;
      active <= 1'b1;
    end else if (active) begin
      if (count == '0) active <= 1'b0;
      else             count  <= count - 1'b1;
    end
  end

  // A load of N gives N+1 cycles of 'active'; expired marks the last one.
  assign expired = active && (count == '0);

endmodule

// File: rtl/eeprom_ctrl.sv
// eeprom_ctrl: single-byte write / random-read sequencer for a 24Cxx EEPROM,
// driving a byte-level I2C engine with START / WRITE / READ / STOP commands.
// Ports:
//   sclk, srst_n      clock / async active-low reset
//   wr_req, rd_req    one-cycle requests (both together = write then read-back)
//   addr, wdata       word address / write data, sampled at acceptance
//   busy              transaction in progress
//   done, err         one-cycle completion pulse; err=1 if a slave NACK was seen
//   rdata             last byte read, held until the next read completes
//   bus_cmd, bus_go   engine command and its one-cycle strobe
//   bus_tx, bus_nack  byte for WRITE / master ACK bit for READ
//   bus_done          engine command-finished pulse
//   bus_ack           slave ACK of the last WRITE (0 = ACK)
//   bus_rx            byte received by READ, valid with bus_done
module eeprom_ctrl
  import eeprom_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEF_DEV_ADDR,
  parameter int unsigned WR_WAIT  = 250000
) (
  input  logic       sclk,
  input  logic       srst_n,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rdata,
  output logic [1:0] bus_cmd,
  output logic       bus_go,
  output logic [7:0] bus_tx,
  output logic       bus_nack,
  input  logic       bus_done,
  input  logic       bus_ack,
  input  logic [7:0] bus_rx
);

  localparam int CNT_W = (WR_WAIT > 1) ? $clog2(WR_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WR_WAIT > 0) ? CNT_W'(WR_WAIT - 1) : '0;

  state_t     state, state_next;
  logic       cmd_sent;     // command of the current step state already strobed
  logic       op_rd;        // current transaction is a read
  logic       pending;      // read-back queued behind the running write
  logic       err_q;        // sticky NACK flag for the running transaction
  logic [7:0] addr_q;
  logic [7:0] wdata_q;

  logic       step_done;
  logic       go_next;
  logic       accept;
  logic       launch_pending;
  logic       nack_seen;
  logic       wait_start;
  logic       wait_expired;
  logic [1:0] cmd_d;
  logic [7:0] tx_d;
  logic       nack_d;

  // bus_done only counts once this state's command has actually gone out.
  assign step_done      = bus_done && cmd_sent && is_step(state);
  assign accept         = (state == S_IDLE) && (wr_req || rd_req);
  assign launch_pending = (state == S_DONE) && pending && !err_q;
  assign nack_seen      = step_done && bus_ack && is_write_step(state);
  assign wait_start     = (state == S_STOP) && (state_next == S_WAIT_WR);

  eeprom_wait_timer #(.CNT_W(CNT_W)) u_wait_timer (
    .sclk    (sclk),
    .srst_n  (srst_n),
    .start   (wait_start),
    .load    (WAIT_LOAD),
    .expired (wait_expired)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge sclk or negedge srst_n) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (!srst_n) state <= S_IDLE;
    else         state <= state_next;
  end

  // ---------------------------------------------------------- next-state comb
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_next unassigned
    // and no latch is inferred.
    state_next = state;
    unique case (state)
      S_IDLE:    if (wr_req || rd_req) state_next = S_START;
      S_START:   if (step_done) state_next = S_DEVW;
      S_DEVW:    if (step_done) state_next = bus_ack ? S_STOP : S_WADDR;
      S_WADDR:   if (step_done) state_next = bus_ack ? S_STOP
                                            : (op_rd ? S_RSTART : S_WDATA);
      S_WDATA:   if (step_done) state_next = S_STOP;
      S_RSTART:  if (step_done) state_next = S_DEVR;
      S_DEVR:    if (step_done) state_next = bus_ack ? S_STOP : S_RDATA;
      S_RDATA:   if (step_done) state_next = S_STOP;
      // Reads, failed writes and a zero wait skip the write-cycle delay.
      S_STOP:    if (step_done) state_next = (op_rd || err_q || WR_WAIT == 0)
                                            ? S_DONE : S_WAIT_WR;
      S_WAIT_WR: if (wait_expired) state_next = S_DONE;
      S_DONE:    state_next = launch_pending ? S_START : S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------- output comb
  always_comb begin
    cmd_d  = CMD_START;
    tx_d   = 8'h00;
    nack_d = 1'b0;
    unique case (state)
      S_DEVW:  begin cmd_d = CMD_WRITE; tx_d = {DEV_ADDR, 1'b0}; end
      S_WADDR: begin cmd_d = CMD_WRITE; tx_d = addr_q;           end
      S_WDATA: begin cmd_d = CMD_WRITE; tx_d = wdata_q;          end
      S_DEVR:  begin cmd_d = CMD_WRITE; tx_d = {DEV_ADDR, 1'b1}; end
      S_RDATA: begin cmd_d = CMD_READ;  nack_d = 1'b1;           end
      S_STOP:  cmd_d = CMD_STOP;
      default: ;
    endcase
    go_next = is_step(state) && !cmd_sent;
    busy    = (state != S_IDLE) && (state != S_DONE);
    done    = (state == S_DONE);
    err     = (state == S_DONE) && err_q;
  end

  // ------------------------------------------------- command and data registers
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      bus_go   <= 1'b0;
      bus_cmd  <= CMD_START;
      bus_tx   <= 8'h00;
      bus_nack <= 1'b0;
      cmd_sent <= 1'b0;
      op_rd    <= 1'b0;
      pending  <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rdata    <= 8'h00;
    end else begin
      // Command fields are loaded with the strobe and then held until the
      // next strobe, so they stay stable for the engine's whole operation.
      bus_go <= go_next;
      if (go_next) begin
        bus_cmd  <= cmd_d;
        bus_tx   <= tx_d;
        bus_nack <= nack_d;
      end
      cmd_sent <= (state_next != state) ? 1'b0 : (cmd_sent || go_next);

      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        op_rd   <= rd_req && !wr_req;
        pending <= wr_req && rd_req;
        err_q   <= 1'b0;
      end else if (launch_pending) begin
        op_rd   <= 1'b1;
        pending <= 1'b0;
        err_q   <= 1'b0;
      end else if (state == S_DONE) begin
        pending <= 1'b0;   // write NACKed: the queued read-back is dropped
      end

      if (nack_seen) err_q <= 1'b1;
      if (state == S_RDATA && step_done) rdata <= bus_rx;
    end
  end

endmodule

// File: tb/tb_eeprom_ctrl.sv
// tb_eeprom_ctrl: directed table-driven bench for eeprom_ctrl with a
// behavioural I2C engine (bus_done 5 cycles after bus_go, selectable NACK).
module tb_eeprom_ctrl;
  import eeprom_pkg::*;

  localparam int WAIT = 10;
  localparam int WIN  = 300;   // cycles allowed per transaction window

  logic       sclk, srst_n;
  logic       wr_req, rd_req;
  logic [7:0] addr, wdata;
  logic       busy, done, err;
  logic [7:0] rdata;
  logic [1:0] bus_cmd;
  logic       bus_go;
  logic [7:0] bus_tx;
  logic       bus_nack;
  logic       bus_done, bus_ack;
  logic [7:0] bus_rx;

  eeprom_ctrl #(.WR_WAIT(WAIT)) dut (
    .sclk(sclk), .srst_n(srst_n), .wr_req(wr_req), .rd_req(rd_req),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .bus_cmd(bus_cmd), .bus_go(bus_go), .bus_tx(bus_tx),
    .bus_nack(bus_nack), .bus_done(bus_done), .bus_ack(bus_ack), .bus_rx(bus_rx)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ engine model
  logic        nack_en;
  logic [7:0]  nack_byte;
  logic [7:0]  rx_val;
  logic [10:0] log_q [$];     // {cmd, nack, tx} of every strobed command
  logic [10:0] ent;

  initial begin
    bus_done = 1'b0;
    bus_ack  = 1'b0;
    bus_rx   = 8'h00;
    forever begin
      @(posedge sclk);
      if (srst_n && bus_go) begin
        ent = {bus_cmd, bus_nack, bus_tx};
        log_q.push_back(ent);
        for (int i = 0; i < 4 && srst_n; i++) @(posedge sclk);
        if (srst_n) begin
          #1;
          bus_ack  = nack_en && (ent[10:9] == CMD_WRITE) && (ent[7:0] == nack_byte);
          bus_rx   = rx_val;
          bus_done = 1'b1;
          @(posedge sclk);
          #1;
          bus_done = 1'b0;
          bus_ack  = 1'b0;
        end
      end
    end
  end

  // ----------------------------------------------------------------- monitor
  int   cyc = 0, stop_cyc = 0, gap = 0;
  int   done_cnt = 0, busy_bad = 0;
  logic last_err = 1'b0;

  always @(negedge sclk) begin
    cyc++;
    if (bus_done && log_q.size() > 0 && log_q[$][10:9] == CMD_STOP) stop_cyc = cyc;
    if (done) begin
      done_cnt++;
      last_err = err;
      gap = cyc - stop_cyc;
      if (busy) busy_bad++;
    end
  end

  // Keep only the fields that matter for each command kind.
  function automatic logic [10:0] norm(input logic [10:0] e);
    case (e[10:9])
      CMD_WRITE: return {e[10:9], 1'b0, e[7:0]};
      CMD_READ:  return {e[10:9], e[8], 8'h00};
      default:   return {e[10:9], 9'h000};
    endcase
  endfunction

  // ------------------------------------------------------------ vector table
  typedef struct {
    logic       wr, rd;
    logic [7:0] addr, wdata;
    logic       nack_en;
    logic [7:0] nack_byte, rx;
    int         dones;
    logic       err;
    logic [7:0] rdata;
    int         gap;      // sampled cycles from STOP's bus_done to done
  } vec_t;

  localparam int NV = 7;
  vec_t        vecs [NV];
  logic [10:0] exp_cmd [NV][16];
  int          exp_n [NV];

  task automatic ec(input int v, input logic [1:0] c, input logic [7:0] tx, input logic n);
    exp_cmd[v][exp_n[v]] = {c, n, tx};
    exp_n[v]++;
  endtask
  task automatic c_s(input int v);                    ec(v, CMD_START, 8'h00, 1'b0); endtask
  task automatic c_w(input int v, input logic [7:0] b); ec(v, CMD_WRITE, b, 1'b0);   endtask
  task automatic c_r(input int v);                    ec(v, CMD_READ, 8'h00, 1'b1);  endtask
  task automatic c_p(input int v);                    ec(v, CMD_STOP, 8'h00, 1'b0);  endtask

  task automatic wr_seq(input int v, input logic [7:0] a, input logic [7:0] d);
    c_s(v); c_w(v, 8'hA0); c_w(v, a); c_w(v, d); c_p(v);
  endtask
  task automatic rd_seq(input int v, input logic [7:0] a);
    c_s(v); c_w(v, 8'hA0); c_w(v, a); c_s(v); c_w(v, 8'hA1); c_r(v); c_p(v);
  endtask

  task automatic fill_table();
    for (int v = 0; v < NV; v++) exp_n[v] = 0;
    // Write with the write-cycle wait: done lands WAIT+1 samples after STOP's bus_done.
    vecs[0] = '{wr:1, rd:0, addr:8'h12, wdata:8'hAA, nack_en:0, nack_byte:8'h00, rx:8'h5A,
                dones:1, err:0, rdata:8'h00, gap:WAIT + 1};
    wr_seq(0, 8'h12, 8'hAA);
    vecs[1] = '{wr:0, rd:1, addr:8'h34, wdata:8'h00, nack_en:0, nack_byte:8'h00, rx:8'h5A,
                dones:1, err:0, rdata:8'h5A, gap:1};
    rd_seq(1, 8'h34);
    // Device-address NACK: straight to STOP, no wait, rdata kept.
    vecs[2] = '{wr:1, rd:0, addr:8'h12, wdata:8'hAA, nack_en:1, nack_byte:8'hA0, rx:8'h77,
                dones:1, err:1, rdata:8'h5A, gap:1};
    c_s(2); c_w(2, 8'hA0); c_p(2);
    vecs[3] = '{wr:0, rd:1, addr:8'h56, wdata:8'h00, nack_en:0, nack_byte:8'h00, rx:8'hC3,
                dones:1, err:0, rdata:8'hC3, gap:1};
    rd_seq(3, 8'h56);
    // NACK on the read device address: no READ issued, rdata kept.
    vecs[4] = '{wr:0, rd:1, addr:8'h56, wdata:8'h00, nack_en:1, nack_byte:8'hA1, rx:8'h99,
                dones:1, err:1, rdata:8'hC3, gap:1};
    c_s(4); c_w(4, 8'hA0); c_w(4, 8'h56); c_s(4); c_w(4, 8'hA1); c_p(4);
    // Simultaneous requests: write, then read-back of the same address.
    vecs[5] = '{wr:1, rd:1, addr:8'h07, wdata:8'h3C, nack_en:0, nack_byte:8'h00, rx:8'h5A,
                dones:2, err:0, rdata:8'h5A, gap:1};
    wr_seq(5, 8'h07, 8'h3C); rd_seq(5, 8'h07);
    // Simultaneous requests with a data NACK: read-back discarded.
    vecs[6] = '{wr:1, rd:1, addr:8'h55, wdata:8'hEE, nack_en:1, nack_byte:8'hEE, rx:8'h11,
                dones:1, err:1, rdata:8'h5A, gap:1};
    wr_seq(6, 8'h55, 8'hEE);
  endtask

  task automatic clear_obs();
    log_q.delete();
    done_cnt = 0;
    busy_bad = 0;
  endtask

  task automatic run_vec(input int v);
    nack_en   = vecs[v].nack_en;
    nack_byte = vecs[v].nack_byte;
    rx_val    = vecs[v].rx;
    clear_obs();
    @(negedge sclk);
    wr_req = vecs[v].wr;
    rd_req = vecs[v].rd;
    addr   = vecs[v].addr;
    wdata  = vecs[v].wdata;
    @(negedge sclk);
    wr_req = 1'b0;
    rd_req = 1'b0;
    addr   = 8'hFF;   // must not leak into the running transaction
    wdata  = 8'hFF;
    repeat (WIN) @(negedge sclk);
    check($sformatf("v%0d cmd count", v), log_q.size(), exp_n[v]);
    for (int i = 0; i < exp_n[v]; i++)
      check($sformatf("v%0d cmd[%0d]", v, i),
            (i < log_q.size()) ? norm(log_q[i]) : 11'h7FF, exp_cmd[v][i]);
    check($sformatf("v%0d done count", v), done_cnt, vecs[v].dones);
    check($sformatf("v%0d err", v), last_err, vecs[v].err);
    check($sformatf("v%0d rdata", v), rdata, vecs[v].rdata);
    check($sformatf("v%0d stop-to-done", v), gap, vecs[v].gap);
    check($sformatf("v%0d busy low with done", v), busy_bad, 0);
    check($sformatf("v%0d idle at end", v), busy, 1'b0);
  endtask

  // -------------------------------------------------------------------- main
  initial begin
    srst_n = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    addr   = 8'h00;
    wdata  = 8'h00;
    nack_en = 1'b0;
    nack_byte = 8'h00;
    rx_val = 8'h5A;
    fill_table();

    repeat (3) @(negedge sclk);
    check("reset outputs", {busy, done, err, rdata, bus_cmd, bus_go, bus_tx, bus_nack}, '0);
    srst_n = 1'b1;
    repeat (2) @(negedge sclk);

    for (int v = 0; v < NV; v++) run_vec(v);

    // Acceptance latency and bus_go pulse shape.
    nack_en = 1'b0;
    rx_val  = 8'h5A;
    clear_obs();
    @(negedge sclk);
    rd_req = 1'b1;
    addr   = 8'h34;
    @(negedge sclk);
    rd_req = 1'b0;
    check("busy after accept", busy, 1'b1);
    check("no go in entry cycle", bus_go, 1'b0);
    @(negedge sclk);
    check("go one cycle after entry", bus_go, 1'b1);
    check("first cmd START", bus_cmd, CMD_START);
    @(negedge sclk);
    check("go is one cycle", bus_go, 1'b0);
    repeat (WIN) @(negedge sclk);
    check("timing run done count", done_cnt, 1);

    // Requests while busy are dropped, including one coinciding with bus_done.
    clear_obs();
    @(negedge sclk);
    wr_req = 1'b1;
    addr   = 8'h21;
    wdata  = 8'h42;
    @(negedge sclk);
    wr_req = 1'b0;
    repeat (15) @(negedge sclk);
    wr_req = 1'b1;
    @(negedge sclk);
    wr_req = 1'b0;
    for (int i = 0; i < 100 && !bus_done; i++) @(negedge sclk);
    check("drop: bus_done reached", bus_done, 1'b1);
    rd_req = 1'b1;
    @(negedge sclk);
    rd_req = 1'b0;
    repeat (WIN) @(negedge sclk);
    check("drop: cmd count", log_q.size(), 5);
    check("drop: done count", done_cnt, 1);
    check("drop: addr byte", (log_q.size() > 2) ? norm(log_q[2]) : 11'h7FF,
          {CMD_WRITE, 1'b0, 8'h21});

    // Reset in the middle of a read, during the word-address WRITE.
    clear_obs();
    @(negedge sclk);
    rd_req = 1'b1;
    addr   = 8'h34;
    @(negedge sclk);
    rd_req = 1'b0;
    for (int i = 0; i < 200 && log_q.size() < 3; i++) @(negedge sclk);
    check("rst: reached WADDR", log_q.size(), 3);
    srst_n = 1'b0;
    #1;
    check("rst: outputs cleared", {busy, done, err, rdata, bus_cmd, bus_go, bus_tx, bus_nack}, '0);
    @(negedge sclk);
    srst_n = 1'b1;
    repeat (3) @(negedge sclk);
    clear_obs();
    rd_req = 1'b1;
    addr   = 8'h34;
    @(negedge sclk);
    rd_req = 1'b0;
    repeat (WIN) @(negedge sclk);
    check("rst: restart cmd count", log_q.size(), 7);
    check("rst: restart begins START", (log_q.size() > 0) ? norm(log_q[0]) : 11'h7FF,
          {CMD_START, 9'h000});
    check("rst: restart done count", done_cnt, 1);
    check("rst: restart rdata", rdata, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eeprom_ctrl.md
# eeprom_ctrl

- Transaction sequencer for the 24Cxx-style EEPROM on the I2C bus.
- Sits between user logic and the byte-level `iic` engine. It turns single-byte write and random-read requests into the engine's START / WRITE / READ / STOP command sequence.
- Checks slave ACKs and enforces the EEPROM internal write-cycle delay.
- Also arbitrates simultaneous write/read requests, so a write can be read back automatically.

## Interface
Parameters:
- DEV_ADDR, 7'b1010_000, 7-bit I2C device address
- WR_WAIT, 250000, sclk cycles to wait after a write STOP (5 ms at 50 MHz); 0 skips the wait

Ports:
- sclk  in  1  system clock; all logic on its rising edge
- srst_n  in  1  reset, asynchronous, active-low
- wr_req  in  1  one-cycle write request
- rd_req  in  1  one-cycle read request
- addr  in  8  word address, sampled at acceptance
- wdata  in  8  write data, sampled at acceptance
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- err  out  1  valid with done; 1 = slave NACK seen
- rdata  out  8  read byte; updated at read completion and held
- bus_cmd  out  2  engine command: 0 START, 1 WRITE, 2 READ, 3 STOP
- bus_go  out  1  one-cycle command strobe
- bus_tx  out  8  byte for WRITE
- bus_nack  out  1  master ACK bit for READ (1 = NACK)
- bus_done  in  1  engine pulse: command finished
- bus_ack  in  1  slave ACK sampled on the last WRITE (0 = ACK)
- bus_rx  in  8  byte received by READ, valid with bus_done

## Operation
- States: IDLE, START, DEVW, WADDR, WDATA, RSTART, DEVR, RDATA, STOP, WAIT_WR, DONE.
- Step states issue exactly one command, then wait for bus_done. bus_done arriving in any other state is ignored.
- Write sequence: START → DEVW ({DEV_ADDR,0}) → WADDR (addr) → WDATA (wdata) → STOP → WAIT_WR → DONE.
- Read sequence: START → DEVW → WADDR → RSTART (START) → DEVR ({DEV_ADDR,1}) → RDATA (READ, bus_nack=1) → STOP → DONE.
- Completing RDATA loads rdata from bus_rx.
- NACK handling:
  - If bus_ack=1 on any WRITE step, go straight to STOP, then DONE with err=1. WAIT_WR is skipped and rdata is unchanged.
  - err is sticky within the transaction and cleared at the next acceptance.
- Acceptance and arbitration:
  - Requests are accepted only in IDLE; requests while busy are dropped.
  - wr_req and rd_req in the same cycle: the write runs first and a pending read is latched for the same addr.
  - After the write's DONE, the pending read starts directly without returning to IDLE.
  - done pulses once per transaction, so two pulses in total.
  - If the write NACKs, the pending read is discarded.
- WAIT_WR: the counter loads WR_WAIT−1 on entry and decrements to 0. WR_WAIT=0 goes STOP → DONE directly.

## Timing
- Reset values:
  - busy=0, done=0, err=0, rdata=8'h00, bus_cmd=0, bus_go=0, bus_tx=8'h00, bus_nack=0
  - state=IDLE, pending=0, counter=0
- Acceptance: request at edge N, busy=1 from N+1. bus_go (START) is a registered pulse asserted the cycle after state entry.
- bus_cmd, bus_tx and bus_nack are stable from bus_go until bus_done.
- The next state is entered on the cycle bus_done is sampled, so the next bus_go follows 1 cycle later.
- done/err assert for one cycle in DONE. busy drops in the same cycle done is high; the next request is accepted the cycle after.
- Bus overhead is 2 cycles per command plus engine time. WAIT_WR adds exactly WR_WAIT cycles.
- Reset asserted mid-transaction: all outputs return to reset values immediately. No STOP is issued; bus recovery is the engine's job.
- bus_done and a new request in the same cycle outside IDLE: the request is dropped.

## Structure
- Package eeprom_pkg holds:
  - command codes CMD_START/WRITE/READ/STOP
  - the state enum
  - default DEV_ADDR
- Sub-module eeprom_wait_timer holds the WR_WAIT down-counter:
  - inputs: start, count value
  - output: expired pulse
- The FSM and the arbitration latch stay in eeprom_ctrl.

## Test plan
The bench uses a behavioural engine model: bus_done 5 cycles after bus_go, configurable ACK, bus_rx=8'h5A.
- Write with WR_WAIT=10, addr=8'h12, wdata=8'hAA, all ACK:
  - commands START, WRITE 8'hA0, WRITE 8'h12, WRITE 8'hAA, STOP
  - done 10 cycles after STOP's bus_done, err=0
- Random read at addr=8'h34:
  - START, WRITE 8'hA0, WRITE 8'h34, START, WRITE 8'hA1, READ with bus_nack=1, STOP
  - done with rdata=8'h5A, err=0
- NACK on WRITE 8'hA0: the next command is STOP, then done with err=1. No WAIT_WR; rdata keeps its prior value.
- wr_req and rd_req together at addr=8'h07: full write, then read of 8'h07; two done pulses, final rdata=8'h5A.
- wr_req pulsed while busy: ignored. No extra commands and only one done.
- srst_n pulled low during WADDR: all outputs at reset values within the same cycle. A new rd_req after release starts cleanly with START.
